// File: rtl/pll_lock_reset_sequencer_if.sv
// Handshake bundle between the PLL lock/reset sequencer and its environment.
// The slave side is the sequencer: it consumes the raw lock and the software
// re-sequence request and drives the per-domain resets plus status.
interface pll_lock_reset_sequencer_if #(
    parameter int N_STAGES = 3
);
    logic                pll_locked;
    logic                sw_rst;
    logic [N_STAGES-1:0] rst_out;
    logic                ready;
    logic [7:0]          lock_loss_cnt;
    logic [1:0]          state_dbg;

    modport master (
        output pll_locked,
        output sw_rst,
        input  rst_out,
        input  ready,
        input  lock_loss_cnt,
        input  state_dbg
    );

    modport slave (
        input  pll_locked,
        input  sw_rst,
        output rst_out,
        output ready,
        output lock_loss_cnt,
        output state_dbg
    );
endinterface

// File: rtl/pll_lock_reset_sequencer.sv
// PLL lock qualifier and staged reset release.
// The raw PLL LOCK is synchronized, must stay high for LOCK_STABLE_CYCLES
// consecutive cycles, then the domain resets are released one at a time in
// ascending order, STAGE_GAP cycles apart. Losing lock after release has begun
// re-asserts every reset at once and bumps a saturating loss counter; sw_rst
// does the same without counting. Everything runs on the PLL output clock.
module pll_lock_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 256,
    parameter int N_STAGES           = 3,
    parameter int CNT_W              = 16
) (
    input logic                       clk,
    input logic                       reset,
    pll_lock_reset_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Last count value of the stability window and of each inter-stage gap.
    // The counter is preloaded with 1 on entry to STABLE because the cycle that
    // moved us out of WAIT_LOCK already saw a synchronized lock.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);

    logic                lock_meta;
    logic                lock_s;

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [CNT_W-1:0]    gap_q,      gap_d;
    logic [N_STAGES-1:0] rst_out_q,  rst_out_d;
    logic                ready_q,    ready_d;
    logic [7:0]          loss_cnt_q, loss_cnt_d;

    // Two-flop synchronizer: pll_locked is asynchronous to clk and is used nowhere else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge values, which is what makes this a two-stage pipeline rather than a single wire.
            lock_meta <= bus.pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // State, counters and all outputs are registered so no reset bit can glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            gap_q      <= '0;
            rst_out_q  <= '1;
            ready_q    <= 1'b0;
            loss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            rst_out_q  <= rst_out_d;
            ready_q    <= ready_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    // Next-state logic: sw_rst first, then loss of lock, then normal sequencing.
    always_comb begin
        // NOTE: every next value defaults to its current value before any branch, so no path through this block can leave a signal unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        rst_out_d  = rst_out_q;
        ready_d    = ready_q;
        loss_cnt_d = loss_cnt_q;

        if (bus.sw_rst) begin
            // Software re-sequence wins over a simultaneous lock loss and is never counted.
            state_d   = WAIT_LOCK;
            cnt_d     = '0;
            gap_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
        end else if (!lock_s && (state_q == RELEASE || state_q == RUN)) begin
            // Lock dropped after release began: slam every reset back on at once.
            state_d   = WAIT_LOCK;
            cnt_d     = '0;
            gap_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
            if (loss_cnt_q != 8'hFF) begin
                loss_cnt_d = loss_cnt_q + 8'd1;
            end
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    cnt_d = '0;
                    if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = CNT_W'(1);
                    end
                end

                STABLE: begin
                    if (!lock_s) begin
                        // A glitch before release is not a loss; restart the window.
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q >= STABLE_LAST) begin
                        // The reset vector is a thermometer code: shifting in a zero
                        // releases the next domain and keeps release strictly ascending.
                        rst_out_d = rst_out_q << 1;
                        cnt_d     = '0;
                        gap_d     = '0;
                        if (rst_out_d == '0) begin
                            ready_d = 1'b1;
                            state_d = RUN;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                RELEASE: begin
                    if (gap_q == GAP_LAST) begin
                        rst_out_d = rst_out_q << 1;
                        gap_d     = '0;
                        if (rst_out_d == '0) begin
                            ready_d = 1'b1;
                            state_d = RUN;
                        end
                    end else begin
                        gap_d = gap_q + CNT_W'(1);
                    end
                end

                RUN: begin
                    // Hold until lock loss or sw_rst, both handled above.
                end

                default: begin
                    state_d = WAIT_LOCK;
                end
            endcase
        end
    end

    assign bus.rst_out       = rst_out_q;
    assign bus.ready         = ready_q;
    assign bus.lock_loss_cnt = loss_cnt_q;
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Self-checking bench for pll_lock_reset_sequencer with 8/4/3 parameters.
// Directed scenarios check the documented edge timing against constants; a
// randomized run checks every cycle against a behavioural model that tracks
// only how many consecutive qualified-lock edges have elapsed.
module tb_pll_lock_reset_sequencer;

    localparam int LSC = 8;
    localparam int GAP = 4;
    localparam int N   = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    pll_lock_reset_sequencer_if #(.N_STAGES(N)) bus ();

    pll_lock_reset_sequencer #(
        .LOCK_STABLE_CYCLES(LSC),
        .STAGE_GAP         (GAP),
        .N_STAGES          (N),
        .CNT_W             (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: lock seen through a two-sample delay; m_run counts
    // consecutive edges with synced lock high and no sw_rst. Every output is a
    // threshold on m_run.
    logic m_s1;
    logic m_s2;
    int   m_run;
    int   m_loss;

    task automatic model_reset();
        m_s1   = 1'b0;
        m_s2   = 1'b0;
        m_run  = 0;
        m_loss = 0;
    endtask

    task automatic model_edge(input logic lk, input logic sw);
        if (sw) begin
            m_run = 0;
        end else if (!m_s2) begin
            if (m_run >= LSC && m_loss < 255) m_loss++;
            m_run = 0;
        end else if (m_run < 1000000) begin
            m_run++;
        end
        m_s2 = m_s1;
        m_s1 = lk;
    endtask

    // {rst_out, ready, lock_loss_cnt, state_dbg}
    function automatic logic [N+10:0] model_vec();
        logic [N-1:0] r;
        logic         rd;
        logic [1:0]   st;
        for (int k = 0; k < N; k++) r[k] = (m_run < LSC + k * GAP);
        rd = (m_run >= LSC + (N - 1) * GAP);
        if (m_run == 0)       st = 2'd0;
        else if (m_run < LSC) st = 2'd1;
        else if (!rd)         st = 2'd2;
        else                  st = 2'd3;
        return {r, rd, 8'(m_loss), st};
    endfunction

    function automatic logic [N+10:0] dut_vec();
        return {bus.rst_out, bus.ready, bus.lock_loss_cnt, bus.state_dbg};
    endfunction

    // Documented timing for a clean lock, edge e counted from E0: {rst_out, ready, state}.
    function automatic logic [5:0] clean_exp(input int e);
        logic [2:0] r;
        logic [1:0] st;
        if (e < 9)       r = 3'b111;
        else if (e < 13) r = 3'b110;
        else if (e < 17) r = 3'b100;
        else             r = 3'b000;
        if (e < 2)       st = 2'd0;
        else if (e < 9)  st = 2'd1;
        else if (e < 17) st = 2'd2;
        else             st = 2'd3;
        return {r, (e >= 17), st};
    endfunction

    // Drive inputs (called at a negedge), take one posedge, advance the model,
    // and return at the following negedge where outputs are sampled.
    task automatic tick(input logic lk, input logic sw);
        bus.pll_locked = lk;
        bus.sw_rst     = sw;
        @(posedge clk);
        model_edge(lk, sw);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.pll_locked = 1'b0;
        bus.sw_rst     = 1'b0;
        reset          = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bus.pll_locked = 1'b0;
        bus.sw_rst     = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() !== {3'b111, 1'b0, 8'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), {3'b111, 1'b0, 8'd0, 2'd0});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        n_checks++;
        if (dut_vec() !== {3'b111, 1'b0, 8'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL idle_no_lock: got %h expected %h", dut_vec(), {3'b111, 1'b0, 8'd0, 2'd0});
        end
    endtask

    task automatic test_clean_lock();
        logic [5:0] got;
        do_reset();
        for (int e = 0; e <= 19; e++) begin
            tick(1'b1, 1'b0);
            got = {bus.rst_out, bus.ready, bus.state_dbg};
            n_checks++;
            if (got !== clean_exp(e)) begin
                n_fail++;
                $display("FAIL clean_lock_E%0d: got %b expected %b", e, got, clean_exp(e));
            end
        end
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL clean_lock_model: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int e = 0; e <= 4; e++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        for (int g = 1; g <= 11; g++) begin
            tick(1'b1, 1'b0);
            if (g == 2) begin
                n_checks++;
                if (bus.state_dbg !== 2'd0) begin
                    n_fail++;
                    $display("FAIL glitch_back_to_wait: got %0d expected 0", bus.state_dbg);
                end
            end
            if (g == 9) begin
                n_checks++;
                if (bus.rst_out !== 3'b111) begin
                    n_fail++;
                    $display("FAIL glitch_window_recount: got %b expected 111", bus.rst_out);
                end
            end
            if (g == 10) begin
                n_checks++;
                if (bus.rst_out !== 3'b110) begin
                    n_fail++;
                    $display("FAIL glitch_first_release: got %b expected 110", bus.rst_out);
                end
            end
        end
        n_checks++;
        if (bus.lock_loss_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL glitch_no_count: got %0d expected 0", bus.lock_loss_cnt);
        end
    endtask

    task automatic test_loss_in_run();
        logic [5:0] got;
        do_reset();
        for (int e = 0; e < 20; e++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        n_checks++;
        if ({bus.rst_out, bus.ready} !== {3'b000, 1'b1}) begin
            n_fail++;
            $display("FAIL loss_F1_still_run: got %b expected 0001", {bus.rst_out, bus.ready});
        end
        tick(1'b0, 1'b0);
        n_checks++;
        if (dut_vec() !== {3'b111, 1'b0, 8'd1, 2'd0}) begin
            n_fail++;
            $display("FAIL loss_F2_reassert: got %h expected %h", dut_vec(), {3'b111, 1'b0, 8'd1, 2'd0});
        end
        for (int e = 0; e <= 18; e++) begin
            tick(1'b1, 1'b0);
            got = {bus.rst_out, bus.ready, bus.state_dbg};
            n_checks++;
            if (got !== clean_exp(e) || bus.lock_loss_cnt !== 8'd1) begin
                n_fail++;
                $display("FAIL relock_E%0d: got %b cnt %0d expected %b cnt 1", e, got, bus.lock_loss_cnt, clean_exp(e));
            end
        end
    endtask

    task automatic test_sw_rst_priority();
        do_reset();
        for (int e = 0; e < 18; e++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        n_checks++;
        if (dut_vec() !== {3'b111, 1'b0, 8'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL sw_rst_over_loss: got %h expected %h", dut_vec(), {3'b111, 1'b0, 8'd0, 2'd0});
        end
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        n_checks++;
        if ({bus.rst_out, bus.state_dbg} !== {3'b111, 2'd0}) begin
            n_fail++;
            $display("FAIL sw_rst_hold_wait: got %b expected 11100", {bus.rst_out, bus.state_dbg});
        end
        for (int k = 1; k <= 16; k++) begin
            tick(1'b1, 1'b0);
            if (k == 1) begin
                n_checks++;
                if (bus.state_dbg !== 2'd1) begin
                    n_fail++;
                    $display("FAIL sw_rst_restart_stable: got %0d expected 1", bus.state_dbg);
                end
            end
            if (k == 8) begin
                n_checks++;
                if (bus.rst_out !== 3'b110) begin
                    n_fail++;
                    $display("FAIL sw_rst_release0: got %b expected 110", bus.rst_out);
                end
            end
        end
        n_checks++;
        if (dut_vec() !== {3'b000, 1'b1, 8'd0, 2'd3}) begin
            n_fail++;
            $display("FAIL sw_rst_ready: got %h expected %h", dut_vec(), {3'b000, 1'b1, 8'd0, 2'd3});
        end
    endtask

    task automatic test_random();
        int   seg;
        logic lk;
        logic sw;
        int   errs;
        do_reset();
        seg  = 0;
        lk   = 1'b0;
        errs = 0;
        for (int c = 0; c < 3000; c++) begin
            if (seg == 0) begin
                lk  = ($urandom_range(0, 9) < 8);
                seg = lk ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 4));
            end
            seg--;
            sw = ($urandom_range(0, 59) == 0);
            tick(lk, sw);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                errs++;
                if (errs <= 10) $display("FAIL random_cycle%0d: got %h expected %h", c, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        do_reset();
        for (int i = 0; i < 260; i++) begin
            for (int k = 0; k < 10; k++) tick(1'b1, 1'b0);
            for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            if (i == 0 || i == 253 || i == 254 || i == 255 || i == 259) begin
                n_checks++;
                if (bus.lock_loss_cnt !== 8'(exp_cnt) || bus.state_dbg !== 2'd0) begin
                    n_fail++;
                    $display("FAIL saturation_event%0d: got cnt %0d state %0d expected cnt %0d state 0", i + 1, bus.lock_loss_cnt, bus.state_dbg, exp_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        for (int k = 0; k < 12; k++) tick(1'b1, 1'b0);
        n_checks++;
        if ({bus.rst_out, bus.lock_loss_cnt} !== {3'b110, 8'd255}) begin
            n_fail++;
            $display("FAIL pre_reset_release: got %h expected %h", {bus.rst_out, bus.lock_loss_cnt}, {3'b110, 8'd255});
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() !== {3'b111, 1'b0, 8'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL async_reset_mid_run: got %h expected %h", dut_vec(), {3'b111, 1'b0, 8'd0, 2'd0});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        bus.pll_locked = 1'b0;
        bus.sw_rst     = 1'b0;
        model_reset();
        test_reset();
        test_clean_lock();
        test_glitch();
        test_loss_in_run();
        test_sw_rst_priority();
        test_random();
        test_saturation();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
